gpio_irq_sequencer: RTL and testbench

GPIO_IRQ_SEQUENCER -- requirements
Module: gpio_irq_sequencer

---
 rtl/gpio_irq_sequencer.sv | 116 +++++++++++
 tb/tb_gpio_irq_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_sequencer.sv
// GPIO interrupt sequencer: initialises a GPIO slave, then captures its data register
// on each interrupt, acknowledges it, and queues the samples for the CPU.
module gpio_irq_sequencer #(
   parameter logic [31:0] INIT_ENABLE = 32'hFFFF_FFFF,
   parameter logic [31:0] INIT_MASK   = 32'h0000_0000,
   parameter logic [31:0] INIT_POL    = 32'h0000_0000,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [4:0]  m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        gpio_irq,
   input  logic [3:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        cpu_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_INIT_EN, ST_INIT_MASK, ST_INIT_POL, ST_IDLE,
      ST_CAPTURE, ST_ACK, ST_HOLD1, ST_HOLD2
   } state_t;

   state_t          state, state_next;
   logic            wr_int;
   logic [4:0]      addr_int;
   logic [31:0]     data_int;

   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow, run;
   logic            push, push_ok, pop, ovf_set, ovf_clr;
   logic            unused_ok;

   assign unused_ok = ^{avs_writedata[31:17], avs_writedata[15:1]};

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_INIT_EN;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      wr_int     = 1'b0;
      addr_int   = 5'd0;
      data_int   = 32'd0;
      case (state)
         ST_INIT_EN:   begin wr_int = 1'b1; addr_int = 5'd4;  data_int = INIT_ENABLE; state_next = ST_INIT_MASK; end
         ST_INIT_MASK: begin wr_int = 1'b1; addr_int = 5'd8;  data_int = INIT_MASK;   state_next = ST_INIT_POL;  end
         ST_INIT_POL:  begin wr_int = 1'b1; addr_int = 5'd12; data_int = INIT_POL;    state_next = ST_IDLE;      end
         ST_IDLE:      if (gpio_irq && run) state_next = ST_CAPTURE;
         ST_CAPTURE:   state_next = ST_ACK;
         ST_ACK:       begin wr_int = 1'b1; addr_int = 5'd16; state_next = ST_HOLD1; end
         ST_HOLD1:     state_next = ST_HOLD2;
         ST_HOLD2:     state_next = ST_IDLE;
         default:      state_next = ST_INIT_EN;
      endcase
   end

   // Reset sits in INIT_EN, so the master bus is gated to stay quiet while reset_n is low.
   assign m_write     = wr_int & reset_n;
   assign m_address   = reset_n ? addr_int : 5'd0;
   assign m_writedata = reset_n ? data_int : 32'd0;

   assign push    = (state == ST_CAPTURE);
   assign pop     = avs_read && (avs_address == 4'd0) && (count != '0);
   assign push_ok = push && ((count != CW'(FIFO_DEPTH)) || pop);
   assign ovf_set = push && !push_ok;
   assign ovf_clr = avs_write && (avs_address == 4'd4) && avs_writedata[16];

   // NOTE: sample storage carries no reset; count and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= m_readdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         run      <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (avs_write && (avs_address == 4'd8)) run <= avs_writedata[0];
      end
   end

   always_comb begin
      avs_readdata = 32'd0;
      case (avs_address)
         4'd0:    if (count != '0) avs_readdata = mem[rd_ptr];
         4'd4:    avs_readdata = {15'd0, overflow, 11'd0, 5'(count)};
         4'd8:    avs_readdata = {31'd0, run};
         default: avs_readdata = 32'd0;
      endcase
   end

   assign cpu_irq = (count != '0);

endmodule

// File: tb/tb_gpio_irq_sequencer.sv
// Randomised bench for gpio_irq_sequencer, checked every cycle against a
// transaction-level model (init write list, sequence step counter, sample queue).
module tb_gpio_irq_sequencer;

   localparam int DEPTH = 4;

   logic        clk, reset_n;
   logic [4:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata, m_readdata;
   logic        gpio_irq;
   logic [3:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata, avs_readdata;
   logic        cpu_irq;
   logic [31:0] gpio_data;

   int n_checks = 0;
   int n_errors = 0;

   // Model: init writes left, position inside the capture sequence (0 = idle), sample queue.
   int          init_idx;
   int          seq_step;
   logic [31:0] q[$];
   logic        ovf_m, run_m;

   gpio_irq_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .gpio_irq(gpio_irq),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .cpu_irq(cpu_irq)
   );

   always #5 clk = ~clk;

   assign m_readdata = (m_address == 5'd0) ? gpio_data : (32'hBAD0_0000 | 32'(m_address));

   function automatic logic [31:0] init_val(int k);
      return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      init_idx = 0;
      seq_step = 0;
      q.delete();
      ovf_m = 1'b0;
      run_m = 1'b1;
   endtask

   task automatic model_step();
      bit pop, push, set_ovf;
      pop     = avs_read && (avs_address == 4'd0) && (q.size() != 0);
      push    = (init_idx == 3) && (seq_step == 1);
      set_ovf = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(gpio_data);
         else                  set_ovf = 1'b1;
      end
      if (avs_write && (avs_address == 4'd4) && avs_writedata[16]) ovf_m = 1'b0;
      if (set_ovf) ovf_m = 1'b1;
      if (init_idx < 3)       init_idx++;
      else if (seq_step != 0) seq_step = (seq_step == 4) ? 0 : seq_step + 1;
      else if (gpio_irq && run_m) seq_step = 1;
      if (avs_write && (avs_address == 4'd8)) run_m = avs_writedata[0];
   endtask

   // Called at a negedge with inputs already set: check this cycle, advance one clock.
   task automatic tick();
      logic        exp_wr;
      logic [4:0]  exp_addr;
      logic [31:0] exp_wd, exp_rd;
      #1;
      exp_wr = 1'b0; exp_addr = 5'd0; exp_wd = 32'd0;
      if (reset_n && init_idx < 3) begin
         exp_wr = 1'b1; exp_addr = 5'(4 * (init_idx + 1)); exp_wd = init_val(init_idx);
      end else if (reset_n && seq_step == 2) begin
         exp_wr = 1'b1; exp_addr = 5'd16;
      end
      case (avs_address)
         4'd0:    exp_rd = (q.size() != 0) ? q[0] : 32'd0;
         4'd4:    exp_rd = {15'd0, ovf_m, 11'd0, 5'(q.size())};
         4'd8:    exp_rd = {31'd0, run_m};
         default: exp_rd = 32'd0;
      endcase
      check("m_write",      32'(m_write),   32'(exp_wr));
      check("m_address",    32'(m_address), 32'(exp_addr));
      check("m_writedata",  m_writedata,    exp_wd);
      check("avs_readdata", avs_readdata,   exp_rd);
      check("cpu_irq",      32'(cpu_irq),   32'(q.size() != 0));
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
   endtask

   task automatic quiet();
      avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
   endtask

   initial begin
      clk = 1'b0; reset_n = 1'b0; gpio_irq = 1'b0; gpio_data = 32'd0;
      avs_address = 4'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
      model_reset();
      @(negedge clk);
      repeat (2) tick();
      avs_address = 4'd8;
      #1 check("reset_run", avs_readdata, 32'd1);

      // Reset release: three init writes, then idle.
      reset_n = 1'b1;
      avs_address = 4'd4;
      repeat (4) tick();
      #1 check("idle_after_init", 32'(m_write), 32'd0);

      // Single pulse, sample A5, CPU pops it.
      gpio_data = 32'hA5; gpio_irq = 1'b1;
      tick();
      gpio_irq = 1'b0;
      repeat (5) tick();
      avs_address = 4'd0; avs_read = 1'b1;
      #1 check("a5_head", avs_readdata, 32'h0000_00A5);
      check("a5_irq_set", 32'(cpu_irq), 32'd1);
      tick();
      avs_read = 1'b0;
      #1 check("a5_irq_clear", 32'(cpu_irq), 32'd0);

      // Held interrupt fills the FIFO and sets overflow while acks continue.
      gpio_irq = 1'b1;
      for (int i = 0; i < 24; i++) begin gpio_data = $urandom; tick(); end
      avs_address = 4'd4;
      #1 check("hold_status", avs_readdata, {15'd0, 1'b1, 11'd0, 5'd4});

      // Pop aligned with a full-FIFO capture: count holds, sample lands at the tail.
      avs_address = 4'd0;
      for (int i = 0; i < 25; i++) begin
         gpio_data = $urandom;
         avs_read  = (seq_step == 1) && (q.size() == DEPTH);
         tick();
      end
      avs_read = 1'b0;

      // Clear overflow, then pause with run=0 while the interrupt stays high.
      avs_address = 4'd4; avs_write = 1'b1; avs_writedata = 32'h0001_0000;
      tick();
      avs_address = 4'd8; avs_writedata = 32'd0;
      tick();
      quiet();
      repeat (12) tick();
      avs_write = 1'b1; avs_writedata = 32'd1;
      tick();
      quiet();
      repeat (8) tick();

      // Reset asserted in the ACK cycle.
      for (int i = 0; i < 40 && seq_step != 2; i++) tick();
      if (seq_step != 2) check("ack_wait_bound", 32'(seq_step), 32'd2);
      reset_n = 1'b0;
      model_reset();
      #1 check("ack_reset_write", 32'(m_write), 32'd0);
      gpio_irq = 1'b0;
      avs_address = 4'd4;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      #1 check("count_after_reset", avs_readdata, 32'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         gpio_irq      = ($urandom_range(0, 3) == 0);
         gpio_data     = $urandom;
         avs_address   = 4'(4 * $urandom_range(0, 3));
         avs_read      = ($urandom_range(0, 2) == 0);
         avs_write     = ($urandom_range(0, 9) == 0);
         avs_writedata = $urandom;
         if (avs_address == 4'd8) avs_writedata[0] = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
